// File: rtl/switches_pkg.sv
// Shared constants for the switches scan controller.
// Register indices, CTRL bit positions and scan FSM encoding.
package switches_pkg;

    localparam logic [1:0] ADDR_STABLE   = 2'd0;
    localparam logic [1:0] ADDR_CHANGED  = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_CTRL     = 2'd3;

    localparam int CTRL_ENABLE  = 0;
    localparam int CTRL_TRIGGER = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STROBE  = 2'd1,
        CAPTURE = 2'd2
    } scanState_e;

endpackage

// File: rtl/switch_debounce.sv
// Whole-word debouncer: a new value is accepted after DEBOUNCE_CNT
// consecutive identical samples; reports which bits flipped on acceptance.
module switch_debounce
    import switches_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample,
    input  logic              sampleValid,
    output logic [DATA_W-1:0] stable,
    output logic [DATA_W-1:0] changeSet
);

    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT);

    logic [DATA_W-1:0] cand;
    logic [DATA_W-1:0] nextCand;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  nextCnt;
    logic              accept;

    always_comb begin
        nextCand = cand;
        nextCnt  = cnt;
        if (sampleValid) begin
            if (sample != cand) begin
                nextCand = sample;
                nextCnt  = CNT_W'(1);
            end else if (cnt != CNT_MAX) begin
                nextCnt = cnt + 1'b1;
            end
        end
    end

    assign accept    = sampleValid && (nextCnt == CNT_MAX) && (nextCand != stable);
    assign changeSet = accept ? (nextCand ^ stable) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand   <= '0;
            cnt    <= '0;
            stable <= '0;
        end else begin
            cand <= nextCand;
            cnt  <= nextCnt;
            if (accept) begin
                stable <= nextCand;
            end
        end
    end

endmodule

// File: rtl/switches_scan_ctrl.sv
// Periodic switch scanner: strobes the switches peripheral, debounces the
// sampled word and exposes STABLE/CHANGED/IRQ_MASK/CTRL to the host.
module switches_scan_ctrl
    import switches_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic              iClk,
    input  logic              iReset_n,
    output logic              oSw_chip_select_n,
    output logic              oSw_read_n,
    input  logic [DATA_W-1:0] iSw_data,
    input  logic              iChip_select_n,
    input  logic              iRead_n,
    input  logic              iWrite_n,
    input  logic [1:0]        iAddress,
    input  logic [31:0]       iWrite_data,
    output logic [31:0]       oRead_data,
    output logic              oIrq
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

    scanState_e        state;
    logic [DIV_W-1:0]  div;
    logic              pending;
    logic              enable;
    logic [DATA_W-1:0] changed;
    logic [DATA_W-1:0] irqMask;
    logic [DATA_W-1:0] stable;
    logic [DATA_W-1:0] changeSet;
    logic [DATA_W-1:0] w1c;
    logic              hostWr;
    logic              hostRd;
    logic              trigger;
    logic              tick;
    logic [31:0]       rdWord;

    assign hostWr  = !iChip_select_n && !iWrite_n;
    assign hostRd  = !iChip_select_n && !iRead_n && iWrite_n;
    assign trigger = hostWr && (iAddress == ADDR_CTRL) && iWrite_data[CTRL_TRIGGER];
    assign tick    = enable && (div == '0);
    assign w1c     = (hostWr && (iAddress == ADDR_CHANGED)) ? iWrite_data[DATA_W-1:0] : '0;

    switch_debounce #(
        .DATA_W      (DATA_W),
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) uDebounce (
        .clk        (iClk),
        .rst_n      (iReset_n),
        .sample     (iSw_data),
        .sampleValid(state == CAPTURE),
        .stable     (stable),
        .changeSet  (changeSet)
    );

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            div <= DIV_MAX;
        end else if (!enable || div == '0) begin
            div <= DIV_MAX;
        end else begin
            div <= div - 1'b1;
        end
    end

    // A new request at the same edge the FSM consumes one is kept.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state             <= IDLE;
            pending           <= 1'b0;
            oSw_chip_select_n <= 1'b1;
            oSw_read_n        <= 1'b1;
        end else begin
            if (tick || trigger) begin
                pending <= 1'b1;
            end else if (state == IDLE && pending) begin
                pending <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (pending) begin
                        state             <= STROBE;
                        oSw_chip_select_n <= 1'b0;
                        oSw_read_n        <= 1'b0;
                    end
                end
                STROBE: begin
                    state             <= CAPTURE;
                    oSw_chip_select_n <= 1'b1;
                    oSw_read_n        <= 1'b1;
                end
                CAPTURE: begin
                    state <= IDLE;
                end
                default: begin
                    state             <= IDLE;
                    oSw_chip_select_n <= 1'b1;
                    oSw_read_n        <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        rdWord = '0;
        unique case (iAddress)
            ADDR_STABLE:   rdWord = 32'(stable);
            ADDR_CHANGED:  rdWord = 32'(changed);
            ADDR_IRQ_MASK: rdWord = 32'(irqMask);
            ADDR_CTRL:     rdWord = 32'(enable);
        endcase
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            enable     <= 1'b0;
            irqMask    <= '0;
            changed    <= '0;
            oRead_data <= '0;
            oIrq       <= 1'b0;
        end else begin
            if (hostWr && iAddress == ADDR_CTRL) begin
                enable <= iWrite_data[CTRL_ENABLE];
            end
            if (hostWr && iAddress == ADDR_IRQ_MASK) begin
                irqMask <= iWrite_data[DATA_W-1:0];
            end
            changed <= (changed & ~w1c) | changeSet;
            if (hostRd) begin
                oRead_data <= rdWord;
            end
            oIrq <= |(changed & irqMask);
        end
    end

endmodule

// File: tb/tb_switches_scan_ctrl.sv
// Directed bench for switches_scan_ctrl with a behavioural switches
// peripheral that latches swIn on the strobe edge.
module tb_switches_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        swCsN;
    logic        swRdN;
    logic [31:0] swIn = 32'h0;
    logic [31:0] swReg = 32'h0;
    logic        csN = 1'b1;
    logic        rdN = 1'b1;
    logic        wrN = 1'b1;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        irq;

    int total = 0;
    int bad = 0;

    switches_scan_ctrl #(
        .DATA_W      (32),
        .SCAN_DIV    (8),
        .DEBOUNCE_CNT(3)
    ) dut (
        .iClk             (clk),
        .iReset_n         (rst_n),
        .oSw_chip_select_n(swCsN),
        .oSw_read_n       (swRdN),
        .iSw_data         (swReg),
        .iChip_select_n   (csN),
        .iRead_n          (rdN),
        .iWrite_n         (wrN),
        .iAddress         (addr),
        .iWrite_data      (wdata),
        .oRead_data       (rdata),
        .oIrq             (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!swCsN && !swRdN) swReg <= swIn;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hostWrite(input logic [1:0] a, input logic [31:0] d);
        csN = 1'b0; wrN = 1'b0; addr = a; wdata = d;
        tick();
        csN = 1'b1; wrN = 1'b1;
    endtask

    task automatic hostRead(input logic [1:0] a, output logic [31:0] d);
        csN = 1'b0; rdN = 1'b0; addr = a;
        tick();
        csN = 1'b1; rdN = 1'b1;
        d = rdata;
    endtask

    task automatic waitStrobe();
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (!swCsN) seen = 1;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL waitStrobe got=timeout want=strobe");
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        bit hiOk = 1;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (swCsN !== 1'b1 || swRdN !== 1'b1) hiOk = 0;
        end
        total++;
        if (!hiOk) begin bad++; $display("FAIL reset_strobes got=low want=high"); end
        total++;
        if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rdata); end
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq); end
        for (int a = 0; a < 4; a++) begin
            hostRead(2'(a), d);
            total++;
            if (d !== 32'h0) begin bad++; $display("FAIL reset_reg%0d got=%h want=0", a, d); end
        end
    endtask

    task automatic test_periodic();
        logic [31:0] d;
        int sCnt = 0;
        int sPos[3] = '{0, 0, 0};
        bit pairOk = 1;
        logic irq27 = 1'bx;
        logic irq28 = 1'bx;
        swIn = 32'h0000_3039;
        hostWrite(2'd2, 32'hFFFF_FFFF);
        hostWrite(2'd3, 32'h1);
        for (int k = 1; k <= 28; k++) begin
            tick();
            if (swCsN !== swRdN) pairOk = 0;
            if (!swCsN) begin
                if (sCnt < 3) sPos[sCnt] = k;
                sCnt++;
            end
            if (k == 27) irq27 = irq;
            if (k == 28) irq28 = irq;
        end
        total++;
        if (sCnt != 3) begin bad++; $display("FAIL per_strobe_count got=%0d want=3", sCnt); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (sPos[i] != 9 + 8 * i) begin
                bad++; $display("FAIL per_strobe_pos%0d got=%0d want=%0d", i, sPos[i], 9 + 8 * i);
            end
        end
        total++;
        if (!pairOk) begin bad++; $display("FAIL per_strobe_pair got=split want=together"); end
        total++;
        if (irq27 !== 1'b0) begin bad++; $display("FAIL per_irq_lag got=%b want=0", irq27); end
        total++;
        if (irq28 !== 1'b1) begin bad++; $display("FAIL per_irq_rise got=%b want=1", irq28); end
        hostRead(2'd0, d);
        total++;
        if (d !== 32'h3039) begin bad++; $display("FAIL per_stable got=%h want=3039", d); end
        hostRead(2'd1, d);
        total++;
        if (d !== 32'h3039) begin bad++; $display("FAIL per_changed got=%h want=3039", d); end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        bit irqLow = 1;
        hostWrite(2'd2, 32'h0);
        tick();
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL gl_mask_irq got=%b want=0", irq); end
        swIn = 32'h0000_D431;
        waitStrobe();
        tick();
        swIn = 32'h0000_3039;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (irq !== 1'b0) irqLow = 0;
        end
        total++;
        if (!irqLow) begin bad++; $display("FAIL gl_irq got=1 want=0"); end
        hostRead(2'd0, d);
        total++;
        if (d !== 32'h3039) begin bad++; $display("FAIL gl_stable got=%h want=3039", d); end
        hostRead(2'd1, d);
        total++;
        if (d !== 32'h3039) begin bad++; $display("FAIL gl_changed got=%h want=3039", d); end
    endtask

    task automatic test_w1c_vs_set();
        logic [31:0] d;
        hostWrite(2'd3, 32'h0);
        repeat (6) tick();
        hostWrite(2'd2, 32'hFFFF_FFFF);
        swIn = 32'h0000_3038;
        for (int i = 0; i < 2; i++) begin
            hostWrite(2'd3, 32'h2);
            repeat (3) tick();
        end
        hostWrite(2'd3, 32'h2);
        repeat (2) tick();
        hostWrite(2'd1, 32'h1);
        hostRead(2'd1, d);
        total++;
        if (d !== 32'h3039) begin bad++; $display("FAIL w1c_set_wins got=%h want=3039", d); end
        hostRead(2'd0, d);
        total++;
        if (d !== 32'h3038) begin bad++; $display("FAIL w1c_stable got=%h want=3038", d); end
        hostWrite(2'd1, 32'h3039);
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL w1c_irq_hold got=%b want=1", irq); end
        tick();
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL w1c_irq_fall got=%b want=0", irq); end
        hostRead(2'd1, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL w1c_cleared got=%h want=0", d); end
    endtask

    task automatic test_trigger();
        logic [31:0] d;
        int lows = 0;
        int lowAt = 0;
        hostWrite(2'd3, 32'h2);
        total++;
        if (swCsN !== 1'b1) begin bad++; $display("FAIL trg_early got=%b want=1", swCsN); end
        tick();
        total++;
        if (swCsN !== 1'b0 || swRdN !== 1'b0) begin
            bad++; $display("FAIL trg_strobe got=%b%b want=00", swCsN, swRdN);
        end
        hostWrite(2'd3, 32'h2);
        for (int k = 3; k <= 14; k++) begin
            tick();
            if (!swCsN) begin lows++; lowAt = k; end
        end
        total++;
        if (lows != 1 || lowAt != 4) begin
            bad++; $display("FAIL trg_overlap got=%0d@%0d want=1@4", lows, lowAt);
        end
        hostRead(2'd3, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL trg_ctrl_read got=%h want=0", d); end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        swIn = 32'h0000_00FF;
        hostWrite(2'd3, 32'h2);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (swCsN !== 1'b1 || swRdN !== 1'b1) begin
            bad++; $display("FAIL ar_strobes got=%b%b want=11", swCsN, swRdN);
        end
        repeat (2) tick();
        #2;
        rst_n = 1'b1;
        repeat (6) tick();
        hostRead(2'd0, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL ar_stable got=%h want=0", d); end
        hostRead(2'd1, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL ar_changed got=%h want=0", d); end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_glitch();
        test_w1c_vs_set();
        test_trigger();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/switches_scan_ctrl.md
Name: switches_scan_ctrl

Overview:
- Controller that periodically sequences reads of the switches peripheral through its chip-select/read strobes.
- Captures each sample and debounces it as a whole word; keeps a stable switch value.
- Records which bits changed and raises a maskable interrupt.
- Exposes STABLE, CHANGED, IRQ_MASK and CTRL as four 32-bit registers on the SoC peripheral bus.

Parameters:
- DATA_W, 32: switch word width; must be <= 32.
- SCAN_DIV, 50000: iClk cycles between automatic scans; must be >= 4.
- DEBOUNCE_CNT, 4: consecutive identical samples required to accept a new value; must be >= 1.

Ports:
- iClk  in  1  system clock
- iReset_n  in  1  asynchronous active-low reset
- oSw_chip_select_n  out  1  chip select to the switches peripheral, active low
- oSw_read_n  out  1  read strobe to the switches peripheral, active low
- iSw_data  in  DATA_W  registered data output of the switches peripheral
- iChip_select_n  in  1  host chip select, active low
- iRead_n  in  1  host read, active low
- iWrite_n  in  1  host write, active low
- iAddress  in  2  host register index
- iWrite_data  in  32  host write data
- oRead_data  out  32  host read data, registered
- oIrq  out  1  interrupt, active high, registered

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (iClk, iReset_n). Reset takes effect immediately, including mid-scan.
  - oSw_chip_select_n=1, oSw_read_n=1, oRead_data=0, oIrq=0.
  - STABLE=0, CHANGED=0, IRQ_MASK=0, CTRL=0.
  - Debounce candidate=0, debounce count=0, divider=SCAN_DIV-1, pending=0, FSM=IDLE.
- Register map (iAddress):
  - 0 STABLE: read-only; writes are ignored.
  - 1 CHANGED: writing 1 to a bit clears it (W1C).
  - 2 IRQ_MASK: read/write.
  - 3 CTRL: bit0 ENABLE (read/write); bit1 TRIGGER (write-1, self-clearing, always reads 0). Other bits read 0.
  - Bits above DATA_W read 0.
- Host access:
  - A read (iChip_select_n=0, iRead_n=0) loads oRead_data at that edge, so data is valid the following cycle. oRead_data holds its value otherwise.
  - A write (iChip_select_n=0, iWrite_n=0) updates the register at that edge.
  - If iRead_n and iWrite_n are both low, the write wins and oRead_data is unchanged.
- Divider:
  - While ENABLE=1, the divider decrements each cycle. At 0 it reloads SCAN_DIV-1 and sets pending.
  - While ENABLE=0, the divider holds at SCAN_DIV-1.
  - A TRIGGER write sets pending regardless of ENABLE. A tick and a trigger in the same cycle produce a single pending, i.e. one scan.
- FSM (IDLE, STROBE, CAPTURE):
  - IDLE: if pending, clear pending and go to STROBE.
  - STROBE: drive oSw_chip_select_n=0 and oSw_read_n=0 for exactly one cycle (the peripheral loads on that edge); go to CAPTURE.
  - CAPTURE: strobes are high; sample iSw_data at the edge leaving CAPTURE; go to IDLE.
  - Pending to sample latency is 3 cycles.
  - Strobes are registered outputs; they are never low outside STROBE.
  - Clearing ENABLE mid-scan lets the current scan finish.
  - Pending set during a scan is serviced on return to IDLE.
- Debounce, applied on each sample s:
  - If s != candidate: candidate=s, count=1.
  - Otherwise count increments, saturating at DEBOUNCE_CNT.
  - When the post-update count equals DEBOUNCE_CNT and candidate != STABLE: CHANGED |= STABLE^candidate, then STABLE=candidate, in the same edge.
  - With DEBOUNCE_CNT=1, every differing sample is accepted immediately.
- CHANGED set vs clear: if a hardware set and a host W1C hit the same bit in the same cycle, the set wins.
- oIrq is registered: oIrq = |(CHANGED & IRQ_MASK), evaluated on the register values after the update, so it lags by one cycle. It deasserts one cycle after the W1C or mask write.

Decomposition:
- Package switches_pkg holds:
  - register index constants (ADDR_STABLE=0, ADDR_CHANGED=1, ADDR_IRQ_MASK=2, ADDR_CTRL=3);
  - CTRL bit positions (CTRL_ENABLE=0, CTRL_TRIGGER=1);
  - FSM state encoding (IDLE, STROBE, CAPTURE).
- One sub-module, switch_debounce: inputs sample and sample_valid; holds candidate, count and STABLE; outputs stable and a per-bit change vector.
- The top level holds the divider, FSM, register file and IRQ logic.

Test Plan (bench parameters: SCAN_DIV=8, DEBOUNCE_CNT=3, the switches peripheral instantiated on iSw_data):
- Reset: hold iReset_n=0 and release while ENABLE=0 -> both strobes stay 1 for 50 cycles; all registers read 0; oIrq=0.
- Periodic debounce: switch input 32'h0000_3039, write CTRL=1, IRQ_MASK=32'hFFFF_FFFF -> one STROBE pulse exactly every 8 cycles. After the 3rd scan, STABLE=32'h3039 and CHANGED=32'h3039; oIrq rises one cycle after the STABLE update.
- Glitch rejection: from STABLE=32'h3039, input 32'hD431 for one scan, then back to 32'h3039 -> STABLE and CHANGED unchanged, oIrq stays 0.
- W1C vs set: CHANGED=32'h3039; write 1 to address 1 with data 32'h0000_0001 in the same cycle a new accepted value sets bit 0 -> bit 0 remains 1. A later write of 32'h3039 clears CHANGED and oIrq falls the next cycle.
- Manual trigger and overlap: with ENABLE=0, write CTRL=2 -> exactly one strobe after 1 cycle and CTRL reads 0. A second TRIGGER written during STROBE produces exactly one further scan after return to IDLE.
- Async reset mid-scan: assert iReset_n=0 while in STROBE -> oSw_chip_select_n and oSw_read_n go high without waiting for a clock edge; no capture occurs; STABLE=0 after release.
